gen_step_ctrl: RTL and testbench

//  Sequences one Game-of-Life generation over field_ram port 1 (read-with-neighbours / write).

---
 rtl/gen_step_ctrl_pkg.sv | 20 ++
 rtl/gen_step_ctrl_state_delay_line.sv | 48 ++++
 rtl/gen_step_ctrl.sv | 179 +++++++++++++++++
 tb/tb_gen_step_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_step_ctrl_pkg.sv
// Shared definitions for the generation sequencer: neighbour count, FSM states, B3/S23 rule.
// Latency: none (types and a pure function).
// Backpressure: none.
package gen_step_ctrl_pkg;

   localparam int NEIGHBOURS_CNT = 8;

   typedef enum logic [2:0] {IDLE, READ, WRITE, DRAIN, DONE} gen_ctrl_state_t;

   function automatic logic life_next(input logic state,
                                      input logic [NEIGHBOURS_CNT-1:0] nbrs);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
         cnt = cnt + {3'b000, nbrs[i]};
      end
      return (cnt == 4'd3) | (state & (cnt == 4'd2));
   endfunction

endpackage

// File: rtl/gen_step_ctrl_state_delay_line.sv
// 1-bit shift FIFO holding new cell states until their old values are no longer read.
// Latency: push visible at head the cycle after; head is combinational.
// Backpressure: none; push while full is legal only together with pop.
module state_delay_line #(
   parameter  int DEPTH = 9,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          push_dat,
   input  logic          pop,
   output logic          pop_dat,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d, wr_idx;

   always_comb begin
      sr_d   = pop ? (sr_q >> 1) : sr_q;
      wr_idx = pop ? (cnt_q - CW'(1)) : cnt_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (i == int'(wr_idx))) begin
            sr_d[i] = push_dat;
         end
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign pop_dat = sr_q[0];
   assign count   = cnt_q;

endmodule

// File: rtl/gen_step_ctrl.sv
// Runs one Life generation in place over field_ram port 1; optional GEN_CNT_EN adds o_gen_cnt.
// Latency: i_step in IDLE -> 2*FIELD_W*FIELD_H active cycles -> o_done pulse.
// Backpressure: none; i_step outside IDLE is dropped.
module gen_step_ctrl
   import gen_step_ctrl_pkg::*;
#(
   parameter  int FIELD_W   = 8,
   parameter  int FIELD_H   = 8,
`ifdef GEN_CNT_EN
   parameter  int GEN_CNT_W = 16,
`endif
   localparam int XW = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
   localparam int YW = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_step,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [XW-1:0]             o_cell_x_adr,
   output logic [YW-1:0]             o_cell_y_adr,
   output logic                      o_w_en,
   output logic                      o_new_cell_state,
   input  logic                      i_cell_state,
`ifdef GEN_CNT_EN
   input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
   output logic [GEN_CNT_W-1:0]      o_gen_cnt
`else
   input  logic [NEIGHBOURS_CNT-1:0] i_nbrs
`endif
);

   localparam int N   = FIELD_W * FIELD_H;
   localparam int L   = FIELD_W + 1;
   localparam int RW  = (N > 1) ? $clog2(N) : 1;
   localparam int DCW = $clog2(L + 1);

   gen_ctrl_state_t state_q, state_d;
   logic [RW-1:0]   r_q;
   logic [XW-1:0]   rx_q, wx_q;
   logic [YW-1:0]   ry_q, wy_q;
   logic            wr_dat_q;
   logic            clr, rd_adv, wr_adv, push, pop, cap, push_dat;
   logic            dl_head;
   logic [DCW-1:0]  dl_cnt;

   state_delay_line #(.DEPTH(L)) u_dly (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (dl_head),
      .count    (dl_cnt)
   );

   always_comb begin
      state_d          = state_q;
      o_busy           = 1'b0;
      o_done           = 1'b0;
      o_cell_x_adr     = '0;
      o_cell_y_adr     = '0;
      o_w_en           = 1'b0;
      o_new_cell_state = 1'b0;
      clr              = 1'b0;
      rd_adv           = 1'b0;
      wr_adv           = 1'b0;
      push             = 1'b0;
      pop              = 1'b0;
      cap              = 1'b0;
      push_dat         = life_next(i_cell_state, i_nbrs);
      case (state_q)
         IDLE: begin
            clr = 1'b1;
            if (i_step) state_d = READ;
         end
         READ: begin
            o_busy       = 1'b1;
            o_cell_x_adr = rx_q;
            o_cell_y_adr = ry_q;
            push         = 1'b1;
            // Once the line is full the oldest entry is retired into wr_dat_q as the new one enters.
            if (int'(r_q) >= L) begin
               pop     = 1'b1;
               cap     = 1'b1;
               state_d = WRITE;
            end else if (int'(r_q) == N - 1) begin
               state_d = DRAIN;
            end else begin
               rd_adv = 1'b1;
            end
         end
         WRITE: begin
            o_busy           = 1'b1;
            o_cell_x_adr     = wx_q;
            o_cell_y_adr     = wy_q;
            o_w_en           = 1'b1;
            o_new_cell_state = wr_dat_q;
            wr_adv           = 1'b1;
            if (int'(r_q) == N - 1) begin
               state_d = DRAIN;
            end else begin
               rd_adv  = 1'b1;
               state_d = READ;
            end
         end
         DRAIN: begin
            o_busy           = 1'b1;
            o_cell_x_adr     = wx_q;
            o_cell_y_adr     = wy_q;
            o_w_en           = 1'b1;
            o_new_cell_state = dl_head;
            pop              = 1'b1;
            wr_adv           = 1'b1;
            if (int'(dl_cnt) == 1) state_d = DONE;
         end
         DONE: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q      <= '0;
         rx_q     <= '0;
         ry_q     <= '0;
         wx_q     <= '0;
         wy_q     <= '0;
         wr_dat_q <= 1'b0;
      end else begin
         if (clr) begin
            r_q  <= '0;
            rx_q <= '0;
            ry_q <= '0;
            wx_q <= '0;
            wy_q <= '0;
         end
         if (rd_adv) begin
            r_q <= r_q + RW'(1);
            if (rx_q == XW'(FIELD_W - 1)) begin
               rx_q <= '0;
               ry_q <= ry_q + YW'(1);
            end else begin
               rx_q <= rx_q + XW'(1);
            end
         end
         if (wr_adv) begin
            if (wx_q == XW'(FIELD_W - 1)) begin
               wx_q <= '0;
               wy_q <= wy_q + YW'(1);
            end else begin
               wx_q <= wx_q + XW'(1);
            end
         end
         if (cap) wr_dat_q <= dl_head;
      end
   end

`ifdef GEN_CNT_EN
   logic [GEN_CNT_W-1:0] gen_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  gen_cnt_q <= '0;
      else if (state_q == DONE) gen_cnt_q <= gen_cnt_q + GEN_CNT_W'(1);
   end

   assign o_gen_cnt = gen_cnt_q;
`endif

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench: 4x4 and 8x8 sequencers each driving a behavioural field_ram port-1 model.
module tb_gen_step_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 4x4 instance and its field model
   logic        step4 = 1'b0, busy4, done4, w_en4, ns4, cs4;
   logic [1:0]  x4, y4;
   logic [7:0]  nbrs4;
   logic [15:0] f4;
   logic        ld4 = 1'b0;
   logic [15:0] ld4_val = '0;
`ifdef GEN_CNT_EN
   logic [1:0]  gc4;
`endif

   // 8x8 instance and its field model
   logic        step8 = 1'b0, busy8, done8, w_en8, ns8, cs8;
   logic [2:0]  x8, y8;
   logic [7:0]  nbrs8;
   logic [63:0] f8;
   logic        ld8 = 1'b0;
   logic [63:0] ld8_val = '0;

   gen_step_ctrl #(
      .FIELD_W(4), .FIELD_H(4)
`ifdef GEN_CNT_EN
      , .GEN_CNT_W(2)
`endif
   ) u4 (
      .clk(clk), .rst(rst), .i_step(step4), .o_busy(busy4), .o_done(done4),
      .o_cell_x_adr(x4), .o_cell_y_adr(y4), .o_w_en(w_en4), .o_new_cell_state(ns4),
      .i_cell_state(cs4),
`ifdef GEN_CNT_EN
      .i_nbrs(nbrs4), .o_gen_cnt(gc4)
`else
      .i_nbrs(nbrs4)
`endif
   );

   gen_step_ctrl #(
      .FIELD_W(8), .FIELD_H(8)
   ) u8 (
      .clk(clk), .rst(rst), .i_step(step8), .o_busy(busy8), .o_done(done8),
      .o_cell_x_adr(x8), .o_cell_y_adr(y8), .o_w_en(w_en8), .o_new_cell_state(ns8),
      .i_cell_state(cs8),
`ifdef GEN_CNT_EN
      .i_nbrs(nbrs8), .o_gen_cnt()
`else
      .i_nbrs(nbrs8)
`endif
   );

   // Out-of-field neighbours read as 0: no toroidal wrap.
   function automatic logic [7:0] nb(input logic [63:0] f, input int w, input int h,
                                     input int x, input int y);
      logic [7:0] n;
      int idx, xx, yy;
      n   = '0;
      idx = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
               xx = x + dx;
               yy = y + dy;
               if (xx >= 0 && xx < w && yy >= 0 && yy < h) n[idx] = f[yy*w+xx];
               idx++;
            end
         end
      end
      return n;
   endfunction

   always_comb begin
      cs4   = f4[{y4, x4}];
      nbrs4 = nb({48'b0, f4}, 4, 4, int'(x4), int'(y4));
      cs8   = f8[{y8, x8}];
      nbrs8 = nb(f8, 8, 8, int'(x8), int'(y8));
   end

   always @(posedge clk) begin
      if (ld4)        f4 <= ld4_val;
      else if (w_en4) f4[{y4, x4}] <= ns4;
      if (ld8)        f8 <= ld8_val;
      else if (w_en8) f8[{y8, x8}] <= ns8;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load4(input logic [15:0] v);
      ld4 = 1'b1; ld4_val = v;
      @(negedge clk);
      ld4 = 1'b0;
   endtask

   task automatic load8(input logic [63:0] v);
      ld8 = 1'b1; ld8_val = v;
      @(negedge clk);
      ld8 = 1'b0;
   endtask

   // Called at a negedge with u4 idle: that cycle is cycle 0. Extra i_step pulses at ign0/ign1.
   task automatic gen4(input int ign0, input int ign1, output int dc, output int wc, output int nd);
      step4 = 1'b1;
      dc = -1; wc = 0; nd = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         step4 = (c == ign0) || (c == ign1);
         if (w_en4) wc++;
         if (done4) begin
            nd++;
            if (dc < 0) dc = c;
         end
      end
      step4 = 1'b0;
   endtask

   task automatic gen8(output int dc);
      step8 = 1'b1;
      dc = -1;
      for (int c = 1; c <= 135; c++) begin
         @(negedge clk);
         step8 = 1'b0;
         if (done8 && dc < 0) dc = c;
      end
   endtask

   int dc, wc, nd;
   logic [63:0] glider_exp [4];

   initial begin
      glider_exp[0] = 64'hC0A0_0000_0000_0000;
      glider_exp[1] = 64'hC080_0000_0000_0000;
      glider_exp[2] = 64'hC0C0_0000_0000_0000;
      glider_exp[3] = 64'hC0C0_0000_0000_0000;

      repeat (2) @(negedge clk);
      chk("rst_busy4", busy4, 0);
      chk("rst_done4", done4, 0);
      chk("rst_wen4",  w_en4, 0);
      chk("rst_adr4",  {x4, y4}, 0);
      chk("rst_ns4",   ns4, 0);
      chk("rst_busy8", busy8, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy4", busy4, 0);

      // Blinker oscillates with period 2
      load4(16'h0222);
      gen4(0, 0, dc, wc, nd);
      chk("blink1_field", f4, 16'h0070);
      chk("blink1_done_cyc", dc, 33);
      chk("blink1_wen_cnt", wc, 16);
      gen4(0, 0, dc, wc, nd);
      chk("blink2_field", f4, 16'h0222);
      chk("blink2_done_cnt", nd, 1);

      // Still-life block
      load4(16'h0660);
      gen4(0, 0, dc, wc, nd);
      chk("block_field", f4, 16'h0660);
      chk("block_wen_cnt", wc, 16);
      chk("block_done_cyc", dc, 33);

      // i_step while busy is dropped
      gen4(5, 20, dc, wc, nd);
      chk("ign_done_cnt", nd, 1);
      chk("ign_done_cyc", dc, 33);
      chk("ign_field", f4, 16'h0660);

      // Reset in cycle 10 (READ r=7 -> (3,1))
      load4(16'h0222);
      step4 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         step4 = 1'b0;
      end
      chk("mid_busy_pre", busy4, 1);
      chk("mid_adr_pre", {x4, y4}, {2'd3, 2'd1});
      rst = 1'b1;
      #1;
      chk("mid_busy_rst", busy4, 0);
      chk("mid_wen_rst", w_en4, 0);
      chk("mid_adr_rst", {x4, y4}, 0);
      chk("mid_done_rst", done4, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      gen4(0, 0, dc, wc, nd);
      chk("post_rst_done_cyc", dc, 33);
      chk("post_rst_wen_cnt", wc, 16);

      // Glider hitting the bottom-right edge collapses into a block
      load8(64'hE080_4000_0000_0000);
      for (int g = 0; g < 4; g++) begin
         gen8(dc);
         chk($sformatf("glider_gen%0d", g + 1), f8, glider_exp[g]);
      end
      chk("glider_done_cyc", dc, 129);

`ifdef GEN_CNT_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("gcnt_rst", gc4, 0);
      for (int g = 1; g <= 5; g++) begin
         gen4(0, 0, dc, wc, nd);
         chk($sformatf("gcnt_gen%0d", g), gc4, 2'(g));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
